// File: rtl/mul_add_rebuilder_pkg.sv
// mul_add_pkg: shared FSM encoding and default widths for the
// multiply-add rebuilder (aq = quotient * div + remainder).
package mul_add_pkg;

   localparam int MUL_N  = 6;
   localparam int MUL_W2 = 2 * MUL_N;
   localparam int CNT_W  = $clog2(MUL_N + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STEP   = 2'd1,
      ADDREM = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/mul_add_rebuilder_controller.sv
// mul_add_controller: sequencing FSM and iteration counter for the
// multiply-add rebuilder. Issues the datapath strobes (ld, step_en,
// addrem_en) and the handshake outputs (ready pulse, busy level).
module mul_add_controller
   import mul_add_pkg::*;
#(
   parameter int N  = MUL_N,
   parameter int CW = CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   output logic o_ld,
   output logic o_step_en,
   output logic o_addrem_en,
   output logic o_ready,
   output logic o_busy
);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_ready;
   logic            r_busy;

   // Strobes are pure decodes of the registered state; ld is the accept
   // strobe and must act on the same edge that leaves IDLE.
   assign o_ld        = (r_state == IDLE) && i_start;
   assign o_step_en   = (r_state == STEP);
   assign o_addrem_en = (r_state == ADDREM);
   assign o_ready     = r_ready;
   assign o_busy      = r_busy;

   // FSM, counter and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state <= STEP;
                  r_cnt   <= CW'(N);
                  r_busy  <= 1'b1;
               end
            end
            STEP: begin
               // cnt==1 means this edge performs the last of N shift steps
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1))
                  r_state <= ADDREM;
            end
            ADDREM: begin
               r_state <= DONE;
               r_ready <= 1'b1;
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mul_add_rebuilder.sv
// mul_add_rebuilder: sequential shift-and-add unit rebuilding a dividend,
// aq = quotient * div + remainder, one multiplier bit per clock, then a
// final remainder add. Optional remainder range check enabled by the
// macro MUL_ADD_REM_CHECK_EN (rem_err = remainder >= div).
module mul_add_rebuilder
   import mul_add_pkg::*;
#(
   parameter int N = MUL_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   quotient,
   input  logic [N-1:0]   div,
   input  logic [N-1:0]   remainder,
   output logic [2*N-1:0] aq,
   output logic           ready,
   output logic           busy,
   output logic           rem_err
);

   localparam int CW = $clog2(N + 1);

   logic             w_ld;
   logic             w_step_en;
   logic             w_addrem_en;
   logic [N:0]       w_upper;
   logic [2*N-1:0]   w_sum;

   // ACC is 2N+1 bits: upper N+1 bits accumulate partial products with
   // the carry kept, lower N bits hold the not-yet-consumed multiplier.
   logic [2*N:0]     r_acc;
   logic [N-1:0]     r_m;
   logic [N-1:0]     r_r;
   logic [2*N-1:0]   r_aq;

   mul_add_controller #(
      .N  (N),
      .CW (CW)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .o_ld        (w_ld),
      .o_step_en   (w_step_en),
      .o_addrem_en (w_addrem_en),
      .o_ready     (ready),
      .o_busy      (busy)
   );

   // Conditional add of the multiplicand and the final remainder add
   always_comb begin
      w_upper = r_acc[2*N:N];
      if (r_acc[0])
         w_upper = r_acc[2*N:N] + {1'b0, r_m};
      w_sum = r_acc[2*N-1:0] + {{N{1'b0}}, r_r};
   end

   // Datapath registers: capture on accept, shift per step, load result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_m   <= '0;
         r_r   <= '0;
         r_aq  <= '0;
      end else begin
         if (w_ld) begin
            r_acc <= {{(N+1){1'b0}}, quotient};
            r_m   <= div;
            r_r   <= remainder;
         end else if (w_step_en) begin
            r_acc <= {1'b0, w_upper, r_acc[N-1:1]};
         end
         // Product plus remainder cannot exceed 2N bits, so no carry out
         if (w_addrem_en)
            r_aq <= w_sum;
      end
   end

   assign aq = r_aq;

`ifdef MUL_ADD_REM_CHECK_EN
   logic r_rem_err;

   // Remainder range flag: valid with ready, held until the next accept
   always_ff @(posedge clk) begin
      if (rst)
         r_rem_err <= 1'b0;
      else if (w_ld)
         r_rem_err <= 1'b0;
      else if (w_addrem_en)
         r_rem_err <= (r_r >= r_m);
   end

   assign rem_err = r_rem_err;
`else
   assign rem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_add_rebuilder.sv
// Self-checking bench for mul_add_rebuilder: scoreboard of expected
// {aq, rem_err} pushed at accept, popped on each ready pulse.
module tb_mul_add_rebuilder;

   localparam int N  = mul_add_pkg::MUL_N;
   localparam int W2 = mul_add_pkg::MUL_W2;
   localparam int CW = mul_add_pkg::CNT_W;

   typedef struct {
      logic [W2-1:0] aq;
      logic          err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [N-1:0]  quotient, div, remainder;
   logic [W2-1:0] aq;
   logic          ready, busy, rem_err;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   int   ready_cnt = 0;
   int   push_cnt  = 0;

   mul_add_rebuilder #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .quotient  (quotient),
      .div       (div),
      .remainder (remainder),
      .aq        (aq),
      .ready     (ready),
      .busy      (busy),
      .rem_err   (rem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int q, input int d, input int r);
      exp_t e;
      e.aq = W2'(q * d + r);
`ifdef MUL_ADD_REM_CHECK_EN
      e.err = (r >= d);
`else
      e.err = 1'b0;
`endif
      return e;
   endfunction

   // Scoreboard monitor: every ready pulse must match the oldest expectation
   always @(negedge clk) begin
      if (ready) begin
         ready_cnt++;
         if (sb.size() == 0) begin
            check("spurious_ready", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("aq", 32'(aq), 32'(e.aq));
            check("rem_err", 32'(rem_err), 32'(e.err));
         end
      end
   end

   // One operation; poke=1 pulses start with junk inputs mid-operation
   task automatic do_op(input int q, input int d, input int r, input bit poke, input int exp_lat);
      int  lat;
      bit  busy_ok;
      exp_t e;
      e = model(q, d, r);
      @(negedge clk);
      quotient = N'(q); div = N'(d); remainder = N'(r); start = 1'b1;
      @(posedge clk);
      sb.push_back(e); push_cnt++;
      #1;
      start = 1'b0;
      quotient = N'($urandom); div = N'($urandom); remainder = N'($urandom);
      lat = 0; busy_ok = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (!busy) busy_ok = 1'b0;
         if (poke && k == 3) begin
            start = 1'b1;
            quotient = N'($urandom); div = N'($urandom); remainder = N'($urandom);
         end
         if (poke && k == 4) start = 1'b0;
         if (ready) begin lat = k; break; end
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("busy_during_op", 32'(busy_ok), 1);
      @(negedge clk);
      check("busy_after_done", 32'(busy), 0);
      repeat (3) @(negedge clk);
      check("aq_held", 32'(aq), 32'(e.aq));
   endtask

   initial begin
      int t[$];
      rst = 1'b1; start = 1'b0; quotient = '0; div = '0; remainder = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_aq", 32'(aq), 0);
      check("rst_ready", 32'(ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_rem_err", 32'(rem_err), 0);
      rst = 1'b0;

      do_op(10, 7, 3, 1'b0, N + 2);
      do_op(63, 63, 62, 1'b0, N + 2);
      do_op(0, 5, 4, 1'b0, N + 2);
      do_op(5, 0, 3, 1'b0, N + 2);
      do_op(12, 5, 1, 1'b1, N + 2);
      do_op(1, 7, 7, 1'b0, N + 2);
      do_op(1, 7, 6, 1'b0, N + 2);

      // Reset in the middle of an operation discards the partial result
      @(negedge clk);
      quotient = 6'd13; div = 6'd11; remainder = 6'd2; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_aq", 32'(aq), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_ready", 32'(ready), 0);
      rst = 1'b0;
      do_op(9, 9, 0, 1'b0, N + 2);

      // start held high for 20 cycles: back-to-back operations
      @(negedge clk);
      quotient = 6'd2; div = 6'd3; remainder = 6'd1; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(model(2, 3, 1)); push_cnt++;
      end
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 20) start = 1'b0;
         if (ready) t.push_back(k);
      end
      check("b2b_pulses", 32'(t.size()), 3);
      if (t.size() == 3) begin
         check("b2b_first_lat", 32'(t[0]), 32'(N + 2));
         check("b2b_gap1", 32'(t[1] - t[0]), 32'(N + 3));
         check("b2b_gap2", 32'(t[2] - t[1]), 32'(N + 3));
      end

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 0);
      check("ready_count", 32'(ready_cnt), 32'(push_cnt));
      check("cnt_width", 32'(CW), 32'($clog2(N + 1)));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mul_add_rebuilder.md
Name: mul_add_rebuilder

Overview:
- Sequential shift-and-add unit that rebuilds a dividend from divider results: aq = quotient * div + remainder.
- Inverse of the restoring divider; sits beside it for self-check and for reconstructing operands.
- Uses the same start/ready handshake and the same controller + datapath style.
- One iteration per clock, N iterations, then a final remainder add.

Parameters:
- N, 6, operand width; result width is 2N.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level request, sampled only in IDLE
- quotient  in  N  multiplier operand
- div  in  N  multiplicand (divisor)
- remainder  in  N  addend, zero-extended to 2N
- aq  out  2N  rebuilt dividend, held stable from DONE until the next accepted start
- ready  out  1  one-cycle pulse; aq valid
- busy  out  1  high from the cycle after acceptance through DONE
- rem_err  out  1  see Optional Feature

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: aq=0, ready=0, busy=0, rem_err=0, state=IDLE, counter=0. Reset wins over every other event, including mid-operation; a partial result is discarded.
- States: IDLE, STEP, ADDREM, DONE.
- IDLE:
  - start=1 at an edge -> capture M=div, R=remainder, ACC={ (N+1)'b0, quotient }, cnt=N; next state STEP.
  - Inputs are sampled only at this edge; later input changes are ignored.
- STEP (one per cycle):
  - If ACC[0]=1: upper = ACC[2N:N] + {1'b0,M} (N+1 bits, carry kept); else upper unchanged.
  - Then ACC = {1'b0, upper, ACC[N-1:1]}, i.e. logical shift right by 1.
  - cnt decrements. When cnt reaches 1 at the edge, next state is ADDREM.
- ADDREM:
  - ACC[2N-1:0] += {N'b0,R}.
  - No overflow is possible: (2^N-1)^2 + 2^N-1 < 2^2N.
  - aq register loads the sum; next state DONE.
- DONE: ready=1 for exactly this cycle; next state IDLE unconditionally.
- Latency: ready is high in the cycle after edge N+1 counted from the accepting edge (edge 0). For N=6, ready appears 8 cycles after acceptance.
- Restart: start still high in IDLE after DONE starts a new operation. Throughput is one result per N+3 cycles.
- start is ignored while busy; no queueing.
- div=0 gives aq=remainder; quotient=0 gives aq=remainder. Neither is an error in base build.
- aq only changes in ADDREM or on reset.

Optional Feature:
- Macro: MUL_ADD_REM_CHECK_EN.
- Defined:
  - rem_err is registered in ADDREM and valid with ready.
  - rem_err=1 iff remainder >= div (this includes div=0).
  - Held until the next acceptance; cleared on reset.
- Undefined: rem_err is tied to 0 and no comparator is built. The port list is unchanged.

Decomposition:
- Package mul_add_pkg holds:
  - state enum (IDLE, STEP, ADDREM, DONE)
  - localparam widths: N, 2N, CNT_W = $clog2(N+1)
- One sub-module, mul_add_controller: FSM plus iteration counter. It drives ld, step_en, addrem_en, ready and busy.
- The top level holds the ACC/M/R datapath registers and the adder.

Test Plan:
- quotient=10, div=7, remainder=3, start pulse -> ready exactly 8 cycles after acceptance, aq=73, busy high for the intervening cycles.
- quotient=63, div=63, remainder=62 -> aq=4031, no wrap. quotient=0, div=5, remainder=4 -> aq=4.
- Accept quotient=12, div=5, remainder=1; change inputs to random values and pulse start at cycle 3 -> aq=61, only one ready pulse.
- Assert rst at cycle 4 of an operation -> next cycle aq=0, busy=0, ready=0. A new start then gives a correct result (9*9+0=81).
- start held high for 20 cycles with quotient=2, div=3, remainder=1 -> back-to-back results aq=7, with ready pulses 9 cycles apart.
- With MUL_ADD_REM_CHECK_EN: quotient=1, div=7, remainder=7 -> aq=14, rem_err=1. Then remainder=6 -> aq=13, rem_err=0. Without the macro, rem_err stays 0.
